rom_32x8: RTL and testbench

ROM_32X8 -- requirements
Module: rom_32x8

---
 rtl/rom_32x8.sv | 67 ++++++
 tb/tb_rom_32x8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rom_32x8.sv
// rom_32x8: 32-word by 8-bit read-only table with a registered, enabled read port.
//   clk        in   rising-edge clock for all state
//   rst        in   asynchronous active-high reset; clears datab and data_valid
//   addrb      in   read address, word index 0..31
//   read_en    in   read enable; datab loads the addressed word only when high
//   datab      out  registered read data, one clock after the enabled address
//   data_valid out  registered copy of read_en, marks cycles holding fresh read data
module rom_32x8 #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addrb,
    input  logic              read_en,
    output logic [DATA_W-1:0] datab,
    output logic              data_valid
);
    logic [DATA_W-1:0] rom_word;
    // Word a is {~a[2:0], a[4:0]}; X or unmatched addresses fall to zero.
    always_comb begin
        case (addrb)
            5'd0:    rom_word = 8'hE0;
            5'd1:    rom_word = 8'hC1;
            5'd2:    rom_word = 8'hA2;
            5'd3:    rom_word = 8'h83;
            5'd4:    rom_word = 8'h64;
            5'd5:    rom_word = 8'h45;
            5'd6:    rom_word = 8'h26;
            5'd7:    rom_word = 8'h07;
            5'd8:    rom_word = 8'hE8;
            5'd9:    rom_word = 8'hC9;
            5'd10:   rom_word = 8'hAA;
            5'd11:   rom_word = 8'h8B;
            5'd12:   rom_word = 8'h6C;
            5'd13:   rom_word = 8'h4D;
            5'd14:   rom_word = 8'h2E;
            5'd15:   rom_word = 8'h0F;
            5'd16:   rom_word = 8'hF0;
            5'd17:   rom_word = 8'hD1;
            5'd18:   rom_word = 8'hB2;
            5'd19:   rom_word = 8'h93;
            5'd20:   rom_word = 8'h74;
            5'd21:   rom_word = 8'h55;
            5'd22:   rom_word = 8'h36;
            5'd23:   rom_word = 8'h17;
            5'd24:   rom_word = 8'hF8;
            5'd25:   rom_word = 8'hD9;
            5'd26:   rom_word = 8'hBA;
            5'd27:   rom_word = 8'h9B;
            5'd28:   rom_word = 8'h7C;
            5'd29:   rom_word = 8'h5D;
            5'd30:   rom_word = 8'h3E;
            5'd31:   rom_word = 8'h1F;
            default: rom_word = 8'h00;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            datab      <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= read_en;
            if (read_en) datab <= rom_word;
        end
    end
endmodule

// File: tb/tb_rom_32x8.sv
// tb_rom_32x8: randomized and directed self-checking bench for rom_32x8 against an arithmetic table model.
module tb_rom_32x8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] addrb = 5'd7;
    logic       read_en = 1'b1;
    logic [7:0] datab;
    logic       data_valid;
    int passed = 0;
    int total = 0;

    rom_32x8 dut (
        .clk(clk),
        .rst(rst),
        .addrb(addrb),
        .read_en(read_en),
        .datab(datab),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_model(input logic [4:0] a);
        logic [2:0] lo;
        lo = a[2:0];
        return {~lo, a};
    endfunction

    // Drive inputs mid-cycle, then advance one rising edge and settle.
    task automatic step(input logic en, input logic [4:0] a);
        @(negedge clk);
        read_en = en;
        addrb = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd7);
            total++;
            if (datab !== 8'h00 || data_valid !== 1'b0) begin
                $display("FAIL reset_hold cyc %0d: datab=%h valid=%b, need 00/0", i, datab, data_valid);
            end else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_spot;
        logic [4:0] addrs [8] = '{5'd0, 5'd7, 5'd8, 5'd15, 5'd24, 5'd31, 5'd20, 5'd21};
        logic [7:0] want [8] = '{8'hE0, 8'h07, 8'hE8, 8'h0F, 8'hF8, 8'h1F, 8'h74, 8'h55};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, addrs[i]);
            total++;
            if (datab !== want[i] || data_valid !== 1'b1) begin
                $display("FAIL spot addr %0d: datab=%h valid=%b, need %h/1", addrs[i], datab, data_valid, want[i]);
            end else passed++;
        end
    endtask

    task automatic test_hold;
        step(1'b1, 5'd15);
        total++;
        if (datab !== 8'h0F) $display("FAIL hold_setup: datab=%h, need 0f", datab);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd24);
            total++;
            if (datab !== 8'h0F || data_valid !== 1'b0) begin
                $display("FAIL hold cyc %0d: datab=%h valid=%b, need 0f/0", i, datab, data_valid);
            end else passed++;
        end
    endtask

    task automatic test_sweep;
        for (int a = 0; a < 32; a++) begin
            step(1'b1, 5'(a));
            total++;
            if (datab !== rom_model(5'(a)) || data_valid !== 1'b1) begin
                $display("FAIL sweep addr %0d: datab=%h valid=%b, need %h/1", a, datab, data_valid, rom_model(5'(a)));
            end else passed++;
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 5'd31);
        total++;
        if (datab !== 8'h1F) $display("FAIL async_setup: datab=%h, need 1f", datab);
        else passed++;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (datab !== 8'h00 || data_valid !== 1'b0) begin
            $display("FAIL async_reset: datab=%h valid=%b, need 00/0", datab, data_valid);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 5'd20);
        total++;
        if (datab !== 8'h74 || data_valid !== 1'b1) begin
            $display("FAIL first_after_reset: datab=%h valid=%b, need 74/1", datab, data_valid);
        end else passed++;
    endtask

    task automatic test_pulse;
        step(1'b0, 5'd3);
        step(1'b1, 5'd8);
        total++;
        if (datab !== 8'hE8 || data_valid !== 1'b1) begin
            $display("FAIL pulse: datab=%h valid=%b, need e8/1", datab, data_valid);
        end else passed++;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 5'(i * 9 + 1));
            total++;
            if (datab !== 8'hE8 || data_valid !== 1'b0) begin
                $display("FAIL pulse_after cyc %0d: datab=%h valid=%b, need e8/0", i, datab, data_valid);
            end else passed++;
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_d;
        logic       exp_v;
        logic       en;
        logic [4:0] a;
        exp_d = datab;
        for (int i = 0; i < 60; i++) begin
            en = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            step(en, a);
            if (en) exp_d = rom_model(a);
            exp_v = en;
            total++;
            if (datab !== exp_d || data_valid !== exp_v) begin
                $display("FAIL random cyc %0d en=%b addr=%0d: datab=%h valid=%b, need %h/%b", i, en, a, datab, data_valid, exp_d, exp_v);
            end else passed++;
        end
    endtask

    initial begin
        #2;
        total++;
        if (datab !== 8'h00 || data_valid !== 1'b0) begin
            $display("FAIL reset_initial: datab=%h valid=%b, need 00/0", datab, data_valid);
        end else passed++;
        test_reset;
        test_spot;
        test_hold;
        test_sweep;
        test_async_reset;
        test_pulse;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
